// File: rtl/attention_feeder.sv
// attention_feeder: streams Q/K/V into register banks, kicks the attention core and returns its result.
module attention_feeder #(
  parameter int N       = 4,
  parameter int DW      = 16,
  parameter int TIMEOUT = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DW-1:0]          in_data,
  output logic [N-1:0][DW-1:0]   core_q,
  output logic [N-1:0][DW-1:0]   core_k,
  output logic [N-1:0][DW-1:0]   core_v,
  output logic                   core_start,
  input  logic                   core_done,
  input  logic [DW-1:0]          core_y,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DW-1:0]          out_data,
  output logic                   out_err,
  output logic                   busy
);
  localparam int CW = $clog2(3 * N);
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [1:0] LOAD = 2'd0, START = 2'd1, WAIT = 2'd2, OUT = 2'd3;
  logic [1:0]                state_q, state_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic [TW-1:0]             timer_q, timer_d;
  logic [N-1:0][DW-1:0]      qv_q, qv_d, kv_q, kv_d, vv_q, vv_d;
  logic                      start_q, start_d, ov_q, ov_d, err_q, err_d;
  logic [DW-1:0]             data_q, data_d;
  assign in_ready   = (state_q == LOAD) && !rst;
  assign busy       = state_q != LOAD;
  assign core_q     = qv_q;
  assign core_k     = kv_q;
  assign core_v     = vv_q;
  assign core_start = start_q;
  assign out_valid  = ov_q;
  assign out_err    = err_q;
  assign out_data   = data_q;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    timer_d = timer_q;
    qv_d    = qv_q;
    kv_d    = kv_q;
    vv_d    = vv_q;
    start_d = 1'b0;
    ov_d    = ov_q;
    err_d   = err_q;
    data_d  = data_q;
    case (state_q)
      LOAD: if (in_valid) begin
        for (int i = 0; i < N; i++) begin
          if (cnt_q == CW'(i))         qv_d[i] = in_data;
          if (cnt_q == CW'(i + N))     kv_d[i] = in_data;
          if (cnt_q == CW'(i + 2 * N)) vv_d[i] = in_data;
        end
        start_d = cnt_q == CW'(3 * N - 1);
        state_d = start_d ? START : LOAD;
        cnt_d   = start_d ? '0 : cnt_q + 1'b1;
      end
      START: begin
        state_d = WAIT;
        timer_d = '0;
      end
      WAIT: if (core_done || timer_q == TW'(TIMEOUT - 1)) begin
        // done has priority over a timeout landing on the same edge
        data_d  = core_done ? core_y : '0;
        err_d   = !core_done;
        ov_d    = 1'b1;
        state_d = OUT;
      end else begin
        timer_d = timer_q + 1'b1;
      end
      default: if (out_ready) begin
        ov_d    = 1'b0;
        err_d   = 1'b0;
        state_d = LOAD;
      end
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= LOAD;
      cnt_q   <= '0;
      timer_q <= '0;
      qv_q    <= '0;
      kv_q    <= '0;
      vv_q    <= '0;
      start_q <= 1'b0;
      ov_q    <= 1'b0;
      err_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      timer_q <= timer_d;
      qv_q    <= qv_d;
      kv_q    <= kv_d;
      vv_q    <= vv_d;
      start_q <= start_d;
      ov_q    <= ov_d;
      err_q   <= err_d;
      data_q  <= data_d;
    end
  end
endmodule

// File: doc/attention_feeder.md
Name: attention_feeder

Overview:
- Initiator/driver for the attention compute core.
- Accepts Q, K and V elements as a serial valid/ready stream and assembles them into three N-element register banks.
- Issues a single-cycle start to the core and holds the vectors stable until the core's done pulse.
- Captures the core's scalar result and returns it on a valid/ready result stream, with a timeout error path if done never arrives.

Parameters:
- N, 4, vector length (elements per Q/K/V).
- DW, 16, element and result width (signed Q8.8).
- TIMEOUT, 16, maximum cycles spent in WAIT before an error result is produced; must be >= 4.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input element valid.
- in_ready  out  1  feeder can accept an element.
- in_data  in  DW  signed element; beat order is q[0..N-1], k[0..N-1], v[0..N-1].
- core_q  out  N x DW  Q vector to core.
- core_k  out  N x DW  K vector to core.
- core_v  out  N x DW  V vector to core.
- core_start  out  1  one-cycle start pulse to core.
- core_done  in  1  core completion pulse (may be one cycle wide).
- core_y  in  DW  core result, valid in the cycle core_done is high.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_data  out  DW  captured result (0 on timeout).
- out_err  out  1  qualifies out_data as a timeout error.
- busy  out  1  high in START, WAIT and OUT.

Behaviour:
- States: LOAD (reset state), START, WAIT, OUT. State and all outputs are registered except in_ready and busy, which decode state.
- Reset values:
  - in_ready = 0 while rst is asserted, otherwise 1 in LOAD.
  - core_start, out_valid, out_err, busy = 0.
  - out_data = 0; core_q/k/v all 0.
  - Beat counter = 0; timer = 0.
- LOAD:
  - A beat is accepted when in_valid && in_ready.
  - Beat index b (0..3N-1) writes: core_q[b] if b < N; core_k[b-N] if b < 2N; otherwise core_v[b-2N].
  - Accepting beat 3N-1 moves to START and clears the counter.
  - in_valid low stalls indefinitely; no timeout applies in LOAD.
- START:
  - core_start = 1 for exactly this one cycle, then unconditionally to WAIT.
  - Timer cleared.
- WAIT:
  - core_start = 0; in_ready = 0.
  - If core_done is sampled high: out_data <= core_y, out_err <= 0, out_valid <= 1, go to OUT.
  - Else timer++. When timer reaches TIMEOUT-1 without done: out_data <= 0, out_err <= 1, out_valid <= 1, go to OUT.
  - core_done and a timeout on the same edge: done wins (no error).
- OUT:
  - out_valid, out_data and out_err are held until out_ready is sampled high.
  - On acceptance: out_valid <= 0, out_err <= 0, go to LOAD. in_ready rises in the next cycle.
- core_done sampled in LOAD, START or OUT is ignored and has no effect.
- core_q/k/v keep their values from the START cycle until overwritten element-by-element by the next LOAD. They never change in START or WAIT.
- Throughput: one job per 3N + 2 + core latency + output-stall cycles. No overlap between loading and compute.
- Reset mid-operation (any state): immediate return to LOAD with reset values. A partial load is discarded, and a pending result is dropped.

Test Plan:
- Nominal job:
  - Stimulus: stub core asserts done 3 cycles after start with core_y = 16'h0280; stream q = 4x16'h0100, k = 4x16'h0100, v = 16'h0100, 0200, 0300, 0400; out_ready held 1.
  - Response: core_start high exactly one cycle, the cycle after beat 11 is accepted. core_q/k/v match the stream and stay stable through done. out_valid rises one cycle after done, out_data = 16'h0280, out_err = 0.
- Input gaps:
  - Stimulus: in_valid toggled 1/0 every cycle during LOAD.
  - Response: exactly 12 beats captured in order; core_start only after the 12th accepted beat.
- Output backpressure:
  - Stimulus: out_ready held 0 for 10 cycles after out_valid rises.
  - Response: out_valid/out_data stable for 10 cycles; in_ready = 0 throughout; on release, out_valid drops next cycle and in_ready = 1.
- Timeout:
  - Stimulus: stub core never asserts done; TIMEOUT = 16.
  - Response: out_valid = 1 with out_err = 1 and out_data = 0, exactly 16 cycles after WAIT is entered. A stray core_done afterwards in OUT is ignored.
- Done/timeout coincidence:
  - Stimulus: stub core asserts done on the last timer cycle with core_y = 16'h7FFF.
  - Response: out_data = 16'h7FFF, out_err = 0.
- Reset mid-operation:
  - Stimulus: assert rst during beat 6, and again during WAIT.
  - Response: in both cases all outputs go to reset values asynchronously; the next job requires a full 12 beats and produces a correct result.
